// File: rtl/afe_frame_sequencer.sv
// Fetches NUM_CH AFE channels per data-ready strobe into shadows and commits them
// atomically to a valid/ready output bus; also runs the AFE diagnostic readout.
module afe_frame_sequencer #(
  parameter int NUM_CH    = 6,
  parameter int DATA_W    = 22,
  parameter int ADDR_W    = 3,
  parameter int RD_LAT    = 2,
  parameter int DIAG_ADDR = 6,
  parameter int DIAG_W    = 14,
  parameter int SIGN_MODE = 0
) (
  input  logic                     clk,
  input  logic                     in_reset,
  input  logic [1:0]               in_data_control,
  input  logic                     in_strm_dn,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic [23:0]              in_strm_data,
  output logic [NUM_CH*DATA_W-1:0] out_samples,
  output logic                     out_valid,
  input  logic                     in_ready,
  output logic                     out_overrun,
  output logic [1:0]               out_diag_er,
  output logic [DIAG_W-1:0]        out_er_data
);

  // state     | meaning
  // S_IDLE    | cleared, mode 00 or after reset
  // S_WAIT    | stream mode, waiting for data-ready strobe
  // S_FETCH   | reading channels; channel==NUM_CH is the commit cycle
  // S_PRESENT | frame on out_samples, waiting for handshake
  // S_DIAG    | diagnostic register readout
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_PRESENT, S_DIAG} state_t;

  localparam int CH_W  = $clog2(NUM_CH + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int FW    = NUM_CH * DATA_W;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_DIAG   = 2'b01;
  localparam logic [1:0] MODE_STREAM = 2'b10;

  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);
  localparam logic [CH_W-1:0]   CH_DONE   = CH_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] DIAG_A    = ADDR_W'(DIAG_ADDR);
  localparam logic [DATA_W-1:0] SIGN_FLIP =
    (SIGN_MODE != 0) ? (DATA_W'(1) << (DATA_W - 1)) : '0;

  state_t             state, state_d;
  logic [CH_W-1:0]    channel, channel_d;
  logic [LAT_W-1:0]   lat, lat_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [FW-1:0]      shadow, shadow_d, samples_d;
  logic               valid_d, overrun_d;
  logic [1:0]         diag_er_d;
  logic [DIAG_W-1:0]  er_data_d;
  logic [DATA_W-1:0]  sample;
  logic               handshake;
  logic               unused_data_bits;

  assign sample           = in_strm_data[DATA_W-1:0] ^ SIGN_FLIP;
  assign handshake        = out_valid & in_ready;
  assign unused_data_bits = ^in_strm_data;

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state       <= S_IDLE;
      channel     <= '0;
      lat         <= '0;
      out_addr    <= '0;
      shadow      <= '0;
      out_samples <= '0;
      out_valid   <= 1'b0;
      out_overrun <= 1'b0;
      out_diag_er <= 2'b00;
      out_er_data <= '0;
    end else begin
      state       <= state_d;
      channel     <= channel_d;
      lat         <= lat_d;
      out_addr    <= addr_d;
      shadow      <= shadow_d;
      out_samples <= samples_d;
      out_valid   <= valid_d;
      out_overrun <= overrun_d;
      out_diag_er <= diag_er_d;
      out_er_data <= er_data_d;
    end
  end

  always_comb begin
    state_d   = state;
    channel_d = channel;
    lat_d     = lat;
    addr_d    = out_addr;
    shadow_d  = shadow;
    samples_d = out_samples;
    valid_d   = out_valid;
    overrun_d = out_overrun;
    diag_er_d = out_diag_er;
    er_data_d = out_er_data;

    case (in_data_control)
      MODE_IDLE: begin
        state_d   = S_IDLE;
        channel_d = '0;
        lat_d     = '0;
        addr_d    = '0;
        shadow_d  = '0;
        samples_d = '0;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        diag_er_d = 2'b00;
        er_data_d = '0;
      end

      MODE_DIAG: begin
        state_d   = S_DIAG;
        channel_d = '0;
        addr_d    = DIAG_A;
        valid_d   = 1'b0;
        if (state != S_DIAG) begin
          lat_d     = '0;
          diag_er_d = 2'b00;
        end else if (out_diag_er == 2'b00) begin
          // a non-zero result code doubles as the "capture done" marker
          if (lat == LAT_LAST) begin
            er_data_d = in_strm_data[DIAG_W-1:0];
            diag_er_d = (in_strm_data[DIAG_W-1:0] == '0) ? 2'b10 : 2'b01;
          end else begin
            lat_d = lat + LAT_W'(1);
          end
        end
      end

      MODE_STREAM: begin
        case (state)
          S_WAIT: begin
            if (in_strm_dn) begin
              state_d   = S_FETCH;
              channel_d = '0;
              lat_d     = '0;
              addr_d    = '0;
            end
          end

          S_FETCH: begin
            if (in_strm_dn) overrun_d = 1'b1;
            if (channel == CH_DONE) begin
              samples_d = shadow;
              valid_d   = 1'b1;
              state_d   = S_PRESENT;
            end else if (lat == LAT_LAST) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (channel == CH_W'(k)) shadow_d[k*DATA_W +: DATA_W] = sample;
              end
              channel_d = channel + CH_W'(1);
              addr_d    = ADDR_W'(channel) + ADDR_W'(1);
              lat_d     = '0;
            end else begin
              lat_d = lat + LAT_W'(1);
            end
          end

          S_PRESENT: begin
            // !out_valid here means the frame was accepted while frozen
            if (handshake || !out_valid) begin
              valid_d = 1'b0;
              if (in_strm_dn) begin
                state_d   = S_FETCH;
                channel_d = '0;
                lat_d     = '0;
                addr_d    = '0;
              end else begin
                state_d = S_WAIT;
              end
            end else if (in_strm_dn) begin
              overrun_d = 1'b1;
            end
          end

          default: begin
            state_d   = S_WAIT;
            channel_d = '0;
            lat_d     = '0;
            addr_d    = '0;
          end
        endcase
      end

      default: begin
        if (state == S_PRESENT && handshake) valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_afe_frame_sequencer.sv
// Scoreboard bench for afe_frame_sequencer: plain and offset-binary instances share
// one AFE RAM model; expected frames are queued at each strobe, compared at out_valid.
module tb_afe_frame_sequencer;
  localparam int NUM_CH = 6;
  localparam int DATA_W = 22;
  localparam int ADDR_W = 3;
  localparam int RD_LAT = 2;
  localparam int DIAG_W = 14;
  localparam int FW     = NUM_CH * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              in_reset, in_strm_dn, in_ready;
  logic [1:0]        in_data_control;
  logic [23:0]       in_strm_data;
  logic [ADDR_W-1:0] out_addr, s_addr;
  logic [FW-1:0]     out_samples, s_samples;
  logic              out_valid, s_valid, out_overrun, s_overrun;
  logic [1:0]        out_diag_er, s_diag_er;
  logic [DIAG_W-1:0] out_er_data, s_er_data;
  logic              unused_tb;

  assign unused_tb = ^{s_addr, s_overrun, s_diag_er, s_er_data};

  // RAM read port: data for an address appears RD_LAT cycles after it is driven
  logic [23:0] ram [0:7];
  logic [23:0] ram_q = '0;
  assign in_strm_data = ram_q;
  always @(posedge clk) ram_q <= ram[out_addr];

  afe_frame_sequencer #(.SIGN_MODE(0)) dut (
    .clk(clk), .in_reset(in_reset), .in_data_control(in_data_control),
    .in_strm_dn(in_strm_dn), .out_addr(out_addr), .in_strm_data(in_strm_data),
    .out_samples(out_samples), .out_valid(out_valid), .in_ready(in_ready),
    .out_overrun(out_overrun), .out_diag_er(out_diag_er), .out_er_data(out_er_data)
  );

  afe_frame_sequencer #(.SIGN_MODE(1)) dut_s (
    .clk(clk), .in_reset(in_reset), .in_data_control(in_data_control),
    .in_strm_dn(in_strm_dn), .out_addr(s_addr), .in_strm_data(in_strm_data),
    .out_samples(s_samples), .out_valid(s_valid), .in_ready(in_ready),
    .out_overrun(s_overrun), .out_diag_er(s_diag_er), .out_er_data(s_er_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [FW-1:0] q_plain[$];
  logic [FW-1:0] q_sign[$];

  function automatic logic [FW-1:0] model_frame(input bit sign);
    logic [FW-1:0]     f;
    logic [DATA_W-1:0] v;
    f = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v = ram[k][DATA_W-1:0];
      if (sign) v[DATA_W-1] = ~v[DATA_W-1];
      f[k*DATA_W +: DATA_W] = v;
    end
    return f;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input bit expect_frame);
    if (expect_frame) begin
      q_plain.push_back(model_frame(1'b0));
      q_sign.push_back(model_frame(1'b1));
    end
    in_strm_dn = 1'b1;
    tick();
    in_strm_dn = 1'b0;
  endtask

  task automatic wait_valid_rise(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", out_valid, 1);
  endtask

  task automatic ramp(input int base, input int step);
    for (int a = 0; a < 8; a++) ram[a] = 24'(base + step * a);
  endtask

  logic valid_q = 1'b0;
  always @(negedge clk) begin
    if (out_valid && !valid_q) begin
      chk("sb_nonempty", q_plain.size() != 0, 1);
      chk("sign_valid", s_valid, 1);
      if (q_plain.size() != 0) begin
        chk("frame", out_samples, q_plain.pop_front());
        chk("frame_sign", s_samples, q_sign.pop_front());
      end
    end
    valid_q = out_valid;
  end

  logic [FW-1:0] frame_a, last_exp;
  logic          saw_valid;

  initial begin
    ramp(24'h100, 1);
    in_reset = 1'b1; in_data_control = 2'b10; in_strm_dn = 1'b0; in_ready = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_addr", out_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", out_overrun, 0);
    chk("rst_diag", out_diag_er, 0);
    chk("rst_samples", out_samples, 0);
    in_reset = 1'b0;
    tick(2);

    // default frame: address sequence and 13-cycle latency
    strobe(1'b1);
    for (int c = 0; c < NUM_CH * RD_LAT; c++) begin
      @(negedge clk);
      chk("addr_seq", out_addr, c / RD_LAT);
    end
    @(negedge clk);
    chk("valid_pre", out_valid, 0);
    @(negedge clk);
    chk("valid_rise", out_valid, 1);

    // strobe coincident with handshake: back-to-back frame, no overrun
    ramp(24'h200, 3);
    strobe(1'b1);
    @(negedge clk);
    chk("hs_clear", out_valid, 0);
    repeat (12) @(negedge clk);
    chk("period_pre", out_valid, 0);
    @(negedge clk);
    chk("period_rise", out_valid, 1);
    chk("b2b_overrun", out_overrun, 0);
    tick(2);

    // offset-binary conversion
    ram[0] = 24'h3FFFFF;
    strobe(1'b1);
    wait_valid_rise(20);
    chk("sign_ch0", s_samples[DATA_W-1:0], 22'h1FFFFF);
    chk("plain_ch0", out_samples[DATA_W-1:0], 22'h3FFFFF);
    tick(2);

    // reset mid-frame with overrun pending
    strobe(1'b0);
    tick(3);
    strobe(1'b0);
    tick(2);
    in_reset = 1'b1;
    tick(3);
    @(negedge clk);
    chk("mid_rst_addr", out_addr, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overrun", out_overrun, 0);
    chk("mid_rst_samples", out_samples, 0);
    in_reset = 1'b0;
    tick(2);
    strobe(1'b1);
    wait_valid_rise(20);
    chk("post_rst_overrun", out_overrun, 0);
    tick(2);

    // backpressure and overrun
    in_ready = 1'b0;
    ramp(24'h100, 1);
    frame_a = model_frame(1'b0);
    strobe(1'b1);
    tick(15);
    ramp(24'h300, 1);
    tick(4);
    strobe(1'b0);
    tick(2);
    @(negedge clk);
    chk("bp_overrun", out_overrun, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_samples", out_samples, frame_a);
    in_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", out_valid, 0);
    in_data_control = 2'b00;
    @(posedge clk);
    #1;
    chk("clr_overrun", out_overrun, 0);
    chk("clr_samples", out_samples, 0);
    in_data_control = 2'b10;
    tick(2);

    // diagnostic readout: zero field, then error field
    ram[6] = 24'h000000;
    in_data_control = 2'b01;
    @(posedge clk);
    @(negedge clk);
    chk("diag_addr", out_addr, 6);
    @(negedge clk);
    chk("diag_pend0", out_diag_er, 2'b00);
    @(negedge clk);
    chk("diag_ok", out_diag_er, 2'b10);
    chk("diag_ok_data", out_er_data, 0);
    in_data_control = 2'b10;
    tick(2);
    chk("diag_hold", out_diag_er, 2'b10);
    chk("diag_exit_addr", out_addr, 0);
    ram[6] = 24'h000040;
    in_data_control = 2'b01;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("diag_pend1", out_diag_er, 2'b00);
    @(negedge clk);
    chk("diag_err", out_diag_er, 2'b01);
    chk("diag_err_data", out_er_data, 14'h0040);
    in_data_control = 2'b10;
    tick(2);

    // freeze at channel 3 with strobes, then resume
    ramp(24'h500, 7);
    last_exp = model_frame(1'b0);
    strobe(1'b1);
    tick(6);
    in_data_control = 2'b11;
    for (int i = 0; i < 10; i++) begin
      in_strm_dn = (i % 3 == 0);
      tick();
    end
    in_strm_dn = 1'b0;
    @(negedge clk);
    chk("frz_addr", out_addr, 3);
    chk("frz_overrun", out_overrun, 0);
    chk("frz_valid", out_valid, 0);
    in_data_control = 2'b10;
    wait_valid_rise(20);
    chk("frz_overrun_after", out_overrun, 0);
    tick(2);

    // abort a partial frame by entering diagnostic mode
    ramp(24'h600, 1);
    strobe(1'b0);
    tick(5);
    in_data_control = 2'b01;
    saw_valid = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_novalid", saw_valid, 0);
    chk("abort_samples", out_samples, last_exp);
    in_data_control = 2'b10;
    tick(2);

    chk("sb_empty", q_plain.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/afe_frame_sequencer.md
# afe_frame_sequencer

Parametrised successor to the pulse-ox AFE data buffer. It reads a configurable number of sample channels from the AFE register-read port after each data-ready strobe and commits them atomically to a flat output bus. The bus is released through a valid/ready handshake. The block also runs the AFE diagnostic readout, and adds a freeze mode, overrun detection and an optional offset-binary conversion. It sits between the AFE read-RAM/address-select logic and the FFT buffers and final computation.

## Interface
Parameters:
- NUM_CH, 6: channels fetched per frame, at addresses 0..NUM_CH-1.
- DATA_W, 22: sample width, taken from in_strm_data[DATA_W-1:0]; DATA_W must be at most 24.
- ADDR_W, 3: read-address width; 2**ADDR_W must be greater than NUM_CH.
- RD_LAT, 2: cycles each address is held before capture; RD_LAT must be at least 1.
- DIAG_ADDR, 6: address of the diagnostic register.
- DIAG_W, 14: width of the diagnostic error field.
- SIGN_MODE, 0: 0 passes samples through unchanged; 1 inverts bit DATA_W-1 (two's complement to offset binary).

Ports:
- clk, in, 1: system clock. This is the only clock.
- in_reset, in, 1: synchronous, active-high reset.
- in_data_control, in, 2: mode. 00 idle/clear, 01 diagnostic, 10 stream, 11 freeze.
- in_strm_dn, in, 1: AFE data-ready strobe.
- out_addr, out, ADDR_W: read address to the AFE RAM.
- in_strm_data, in, 24: read data, valid RD_LAT cycles after out_addr changes.
- out_samples, out, NUM_CH*DATA_W: committed frame; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid, out, 1: frame available.
- in_ready, in, 1: consumer accepts the frame.
- out_overrun, out, 1: sticky flag; a strobe was dropped.
- out_diag_er, out, 2: 00 pending, 10 no error, 01 error.
- out_er_data, out, DIAG_W: captured diagnostic field.

## Operation
Reset, or mode 00, forces the following:
- state IDLE;
- out_addr, out_samples, out_er_data and all internal shadow registers to 0;
- out_valid, out_overrun and out_diag_er to 0.

Mode 01 (diagnostic):
- From any state, abort any frame and drive out_addr=DIAG_ADDR.
- Capture in_strm_data[DIAG_W-1:0] into out_er_data on the RD_LAT-th cycle.
- Set out_diag_er to 10 if the captured field is zero, otherwise 01.
- Hold the result until the mode changes.
- out_valid is cleared on entry.

Mode 10 (stream) uses the states WAIT, FETCH and PRESENT:
- **WAIT:** in_strm_dn=1 moves to FETCH with channel=0, lat=0 and out_addr=0.
- **FETCH:** hold out_addr=channel for RD_LAT cycles.
  - When lat==RD_LAT-1, write in_strm_data[DATA_W-1:0] (MSB inverted if SIGN_MODE=1) into shadow[channel], then advance channel, set out_addr=channel+1 and lat=0.
  - After channel NUM_CH-1, copy all shadows to out_samples in one cycle, assert out_valid, and go to PRESENT.
- **PRESENT:** out_valid and out_samples are held stable. When out_valid&in_ready, clear out_valid and return to WAIT.
- **Simultaneous handshake and strobe:** if in_strm_dn=1 in the same cycle as the handshake, go directly to FETCH; the strobe is not dropped.
- **Overrun:** in_strm_dn=1 in FETCH, or in PRESENT without a handshake that cycle, is dropped and sets out_overrun. The in-progress frame is unaffected.
- out_samples changes only on commit or clear; a partial frame is never visible.

Mode 11 (freeze):
- All state, counters, out_addr and outputs hold their values.
- in_strm_dn is ignored and does not set out_overrun.
- The handshake is still honoured in PRESENT: out_valid clears, but the state remains PRESENT until the mode returns to 10.
- On return to 10, resume exactly where frozen. If out_valid was cleared during freeze, the block goes to WAIT.

Mode transitions:
- 10→01 discards the partial frame; committed out_samples are kept.
- 01→10 enters WAIT with out_addr=0 and out_diag_er held.

## Timing
- The strobe is sampled at edge T.
- Channel k's address is driven during cycles T+1+k·RD_LAT through T+(k+1)·RD_LAT. Its capture happens at the edge ending cycle T+(k+1)·RD_LAT.
- out_valid rises after edge T+NUM_CH·RD_LAT+1. With defaults this is 13 cycles after the strobe.
- Minimum frame period with in_ready held high is NUM_CH·RD_LAT+2 cycles.
- Diagnostic: mode 01 is first sampled at edge D. out_addr=DIAG_ADDR is valid after D, and out_diag_er/out_er_data are valid after edge D+RD_LAT.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- **Reset and clear:** hold in_reset=1 for 3 cycles, in mode 10 mid-frame. All outputs must be 0 and the next strobe must start a clean frame.
- **Default frame:** ramp the RAM data so address a returns 0x100+a, pulse in_strm_dn, hold in_ready=1. out_valid rises 13 cycles later with channel k = 0x100+k, and out_addr follows the sequence 0,0,1,1,…,5,5.
- **SIGN_MODE=1:** address 0 returns 0x3FFFFF. Channel 0 must read 0x1FFFFF.
- **Backpressure and overrun:** hold in_ready=0 and send two strobes 20 cycles apart. out_overrun goes to 1 and out_samples stays at frame 1. Raising in_ready clears out_valid, and mode 00 clears out_overrun.
- **Diagnostic:** address 6 returns 0x0000, then 0x0040. out_diag_er must be 10 with out_er_data=0, then 01 with out_er_data=0x0040, each valid RD_LAT+1 cycles after entering mode 01.
- **Freeze and abort:** switch to mode 11 at channel 3 for 10 cycles, pulsing in_strm_dn. Then return to 10: out_overrun stays 0 and the frame completes with correct data. Next, switch 10→01 mid-frame: no out_valid is raised and the previous out_samples are unchanged.
